// File: rtl/gol_seed_writer_if.sv
// gol_seed_writer_if: control, grant and memory write-port bundle for the board seed writer
interface gol_seed_writer_if #(
  parameter int N = 8,
  parameter int A = 16
);
  logic         start;
  logic         seed_load;
  logic [15:0]  seed_value;
  logic [1:0]   density;
  logic         grant;
  logic [A-1:0] mem_address;
  logic [N-1:0] write_value;
  logic         write_enable;
  logic         busy;
  logic         done;
  logic [A-1:0] word_count;
  modport master (
    output start, seed_load, seed_value, density, grant,
    input  mem_address, write_value, write_enable, busy, done, word_count
  );
  modport slave (
    input  start, seed_load, seed_value, density, grant,
    output mem_address, write_value, write_enable, busy, done, word_count
  );
endinterface

// File: rtl/gol_seed_writer.sv
// gol_seed_writer: fills the Game-of-Life board memory with LFSR-derived cells at a selectable density
module gol_seed_writer #(
  parameter int          N    = 8,
  parameter int          A    = 16,
  parameter int          O    = 38400,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input logic clk,
  input logic rst,
  gol_seed_writer_if.slave sw
);
  typedef enum logic [1:0] {IDLE, FILL, FINISH} state_t;
  state_t       state_q, state_d;
  logic [15:0]  lfsr_q, lfsr_d;
  logic [A-1:0] addr_q, addr_d;
  logic [A-1:0] count_q, count_d;
  logic [N-1:0] word;
  logic         last;
  // N Galois steps per granted word so every word sees fresh bits
  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    logic [15:0] r;
    r = l;
    for (int i = 0; i < N; i++) r = r[0] ? ((r >> 1) ^ 16'hB400) : (r >> 1);
    return r;
  endfunction
  assign last = addr_q == A'(O - 1);
  // density shaping: AND of two bytes thins the board, OR thickens it
  always_comb begin
    word = sw.density == 2'b00 ? lfsr_q[N-1:0] :
           sw.density == 2'b01 ? lfsr_q[N-1:0] & lfsr_q[N+7:8] :
           sw.density == 2'b10 ? lfsr_q[N-1:0] | lfsr_q[N+7:8] : '0;
  end
  // next-state logic; writes only advance on granted cycles
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    addr_d  = addr_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (sw.seed_load) lfsr_d = sw.seed_value == 16'd0 ? SEED : sw.seed_value;
        else if (sw.start) begin
          addr_d  = '0;
          count_d = '0;
          state_d = FILL;
        end
      end
      FILL: begin
        if (sw.grant) begin
          lfsr_d  = lfsr_step(lfsr_q);
          count_d = count_q + 1'b1;
          if (last) state_d = FINISH;
          else addr_d = addr_q + 1'b1;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state registers with asynchronous abort
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lfsr_q  <= SEED;
      addr_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      addr_q  <= addr_d;
      count_q <= count_d;
    end
  end
  assign sw.mem_address  = addr_q;
  assign sw.write_value  = state_q == FILL ? word : '0;
  assign sw.write_enable = state_q == FILL && sw.grant;
  assign sw.busy         = state_q != IDLE;
  assign sw.done         = state_q == FINISH;
  assign sw.word_count   = count_q;
endmodule

// File: doc/gol_seed_writer.md
Name: gol_seed_writer

Overview:
- Upstream fill stage for the Game-of-Life board memory (O words of N cells, 640x480 cells packed 8 per byte).
- Writes a pseudo-random initial board into the memory's shared write port, one word per granted cycle, using a 16-bit Galois LFSR with selectable live-cell density.
- Exists so a board can be seeded without the address-derived init pattern.
- Runs while the generation controller is idle; the top-level mux selects this block's address/data/enable while Busy=1.

Parameters:
- N, 8, cells per memory word (WriteValue width; N <= 8).
- A, 16, memory address width.
- O, 38400, number of board words to fill.
- SEED, 16'hACE1, LFSR reset value; also substituted for a zero seed.

Ports:
- Clock  in  1  system clock; all state on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  level; sampled each cycle in IDLE; high begins a fill.
- SeedLoad  in  1  load LFSR from SeedValue (IDLE only).
- SeedValue  in  16  new seed.
- Density  in  2  00=50%, 01=25%, 10=75%, 11=clear board.
- Grant  in  1  memory port available this cycle; low stalls the fill.
- MemAddress  out  A  word address being written.
- WriteValue  out  N  word data.
- WriteEnable  out  1  write strobe to memory.
- Busy  out  1  fill in progress.
- Done  out  1  one-cycle pulse after the last word is written.
- WordCount  out  A  words written so far (for the hex display).

Behaviour:
- Reset (async): state IDLE; lfsr=SEED; addr=0.
  - All outputs 0: MemAddress=0, WriteValue=0, WriteEnable=0, Busy=0, Done=0, WordCount=0.
- States: IDLE, FILL, FINISH.
- IDLE:
  - SeedLoad=1 → lfsr <= (SeedValue==0 ? SEED : SeedValue). Start is ignored that cycle; SeedLoad wins.
  - Otherwise, Start=1 → addr<=0, go to FILL.
  - SeedLoad and Start outside IDLE are ignored.
- FILL:
  - WriteEnable = Grant (combinational; state==FILL is required).
  - MemAddress = addr (registered).
  - WriteValue (combinational from the current lfsr):
    - 00: lfsr[N-1:0]
    - 01: lfsr[N-1:0] & lfsr[N+7:8]
    - 10: lfsr[N-1:0] | lfsr[N+7:8]
    - 11: all zeros
  - On a granted cycle:
    - addr <= addr+1.
    - lfsr advances N single-bit Galois steps in one clock (polynomial x^16+x^14+x^13+x^11+1, mask 16'hB400; shift right, XOR mask when the shifted-out bit is 1).
  - On a Grant=0 cycle, addr and lfsr hold and no write occurs.
  - A granted write at addr==O-1 → FINISH; addr is not incremented past O-1 (no wrap).
- FINISH: Done=1 for exactly this cycle, WriteEnable=0, then IDLE.
- Busy = (state != IDLE); Busy is still 1 in FINISH and falls together with Done.
- WordCount:
  - Equals the number of completed writes.
  - Holds O after completion until the next Start, which clears it to 0.
- Latency:
  - Start sampled at edge k → first write in cycle k+1 if Grant=1.
  - With Grant held high: O write cycles, Done in cycle k+O+1.
- The LFSR is not re-seeded by Start; consecutive fills continue the sequence.
- Reset mid-fill: immediate abort, no Done, lfsr back to SEED; memory contents are left partially written.
- Density is sampled every cycle; changing it mid-fill affects subsequent words only.

Test Plan:
- Reset, Start=1 one cycle, Grant=1, Density=00 → addr 0 written with 8'hE1. Exactly 38400 WriteEnable cycles over addresses 0..38399, Done pulse 1 cycle, Busy low same cycle, WordCount=38400.
- Density=01 and 10 after reset → first word 8'hA0 and 8'hED respectively. Density=11 → every written word 8'h00.
- Grant low for 5 cycles while addr=10 → no writes, MemAddress holds 10, WriteValue unchanged. Fill completes in 38405 cycles after Start; no address skipped or duplicated (scoreboard all addresses once).
- SeedLoad with SeedValue=16'h0000 then Start → first word 8'hE1 (SEED substituted). SeedValue=16'h1234 → first word 8'h34. SeedLoad+Start same cycle → no fill starts.
- Async Reset asserted mid-cycle at addr=100 → Busy, WriteEnable, MemAddress go 0 without a clock edge. No Done; a following Start restarts at addr 0 with word 8'hE1.
- Start asserted during FILL and FINISH → ignored, single Done. Start held high continuously → back-to-back fills, the second starting from the continued LFSR state (first word ≠ 8'hE1 checked against the reference model).
